// File: rtl/axi4_lite_dmem_master_pkg.sv
// Shared encodings for the data-memory AXI4-Lite initiator: access sizes,
// AXI response codes and FSM states.
package axi4_lite_dmem_master_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AWW  = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_dmem_master_if.sv
// AXI4-Lite channel bundle between the data-memory initiator and its responder.
// Widths follow the instance parameters; master drives VALIDs, slave drives READYs.
interface axi4_lite_dmem_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic                  AW_VALID;
  logic                  AW_READY;
  logic [ADDR_W-1:0]     AW_ADDR;
  logic                  W_VALID;
  logic                  W_READY;
  logic [DATA_W-1:0]     W_DATA;
  logic [DATA_W/8-1:0]   W_STRB;
  logic                  B_VALID;
  logic                  B_READY;
  logic [1:0]            B_RESP;
  logic                  AR_VALID;
  logic                  AR_READY;
  logic [ADDR_W-1:0]     AR_ADDR;
  logic                  R_VALID;
  logic                  R_READY;
  logic [DATA_W-1:0]     R_DATA;
  logic [1:0]            R_RESP;

  modport master (
    output AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY, AR_VALID, AR_ADDR, R_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );

  modport slave (
    input  AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY, AR_VALID, AR_ADDR, R_READY,
    output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );

endinterface

// File: rtl/axi4_lite_dmem_master_lane_align.sv
// Byte-lane steering for data-memory accesses: store shift/strobes, misalignment
// detect, and load lane select with sign/zero extension. Purely combinational.
module dmem_lane_align
  import axi4_lite_dmem_master_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [OFF_W-1:0]    i_off,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]   i_rdata,
  output logic                o_misaligned,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_strb,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int STRB_W = DATA_W/8;

  logic [OFF_W+2:0]  w_shift;
  logic [DATA_W-1:0] w_lane;

  assign w_shift = {i_off, 3'b000};
  assign w_lane  = i_rdata >> w_shift;
  assign o_wdata = i_wdata << w_shift;

  always_comb begin
    o_misaligned = 1'b0;
    o_strb       = '0;
    o_rdata      = w_lane;
    case (i_size)
      SIZE_B: begin
        o_strb  = STRB_W'(1) << i_off;
        o_rdata = i_unsigned ? DATA_W'(w_lane[7:0]) : {{(DATA_W-8){w_lane[7]}}, w_lane[7:0]};
      end
      SIZE_H: begin
        o_misaligned = i_off[0];
        o_strb       = STRB_W'(3) << i_off;
        o_rdata      = i_unsigned ? DATA_W'(w_lane[15:0]) : {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]};
      end
      SIZE_W: begin
        o_misaligned = (i_off[1:0] != 2'b00);
        o_strb       = STRB_W'(4'hF) << i_off;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi4_lite_dmem_master.sv
// AXI4-Lite initiator for CPU loads/stores: one transaction in flight, 3-cycle zero-wait
// latency (1 for misaligned), STALL held until the single RSP_VALID pulse; READY stalls tolerated.
module axi4_lite_dmem_master
  import axi4_lite_dmem_master_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                REQ_VALID,
  input  logic                REQ_WE,
  input  logic [ADDR_W-1:0]   REQ_ADDR,
  input  logic [DATA_W-1:0]   REQ_WDATA,
  input  logic [1:0]          REQ_SIZE,
  input  logic                REQ_UNSIGNED,
  output logic                STALL,
  output logic                RSP_VALID,
  output logic [DATA_W-1:0]   RSP_RDATA,
  output logic                RSP_ERR,
  axi4_lite_dmem_master_if.master bus
);

  localparam int OFF_W = $clog2(DATA_W/8);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_err;

  logic                w_idle;
  logic [OFF_W-1:0]    w_off;
  logic [1:0]          w_size;
  logic                w_unsigned;
  logic [DATA_W-1:0]   w_wdata_in;
  logic [DATA_W-1:0]   w_wdata_lane;
  logic [DATA_W-1:0]   w_rdata_ext;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_misaligned;

  // In IDLE the live request feeds the aligner so misalignment is known before capture.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_off      = w_idle ? REQ_ADDR[OFF_W-1:0] : r_addr[OFF_W-1:0];
  assign w_size     = w_idle ? REQ_SIZE            : r_size;
  assign w_unsigned = w_idle ? REQ_UNSIGNED        : r_unsigned;
  assign w_wdata_in = w_idle ? REQ_WDATA           : r_wdata;

  dmem_lane_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .i_off        (w_off),
    .i_size       (w_size),
    .i_unsigned   (w_unsigned),
    .i_wdata      (w_wdata_in),
    .i_rdata      (bus.R_DATA),
    .o_misaligned (w_misaligned),
    .o_wdata      (w_wdata_lane),
    .o_strb       (w_strb),
    .o_rdata      (w_rdata_ext)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.AW_VALID = 1'b0;
    bus.AW_ADDR  = '0;
    bus.W_VALID  = 1'b0;
    bus.W_DATA   = '0;
    bus.W_STRB   = '0;
    bus.B_READY  = 1'b0;
    bus.AR_VALID = 1'b0;
    bus.AR_ADDR  = '0;
    bus.R_READY  = 1'b0;
    STALL        = (r_state != ST_RESP) && (!w_idle || REQ_VALID);
    RSP_VALID    = 1'b0;
    RSP_RDATA    = '0;
    RSP_ERR      = 1'b0;
    case (r_state)
      ST_IDLE: if (REQ_VALID) w_next = w_misaligned ? ST_RESP : (REQ_WE ? ST_AWW : ST_AR);
      ST_AR: begin
        bus.AR_VALID = 1'b1;
        bus.AR_ADDR  = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        if (bus.AR_READY) w_next = ST_R;
      end
      ST_R: begin
        bus.R_READY = 1'b1;
        if (bus.R_VALID) w_next = ST_RESP;
      end
      ST_AWW: begin
        bus.AW_VALID = !r_aw_done;
        bus.AW_ADDR  = r_aw_done ? '0 : {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        bus.W_VALID  = !r_w_done;
        bus.W_DATA   = r_w_done ? '0 : w_wdata_lane;
        bus.W_STRB   = r_w_done ? '0 : w_strb;
        if ((r_aw_done || bus.AW_READY) && (r_w_done || bus.W_READY)) w_next = ST_B;
      end
      ST_B: begin
        bus.B_READY = 1'b1;
        if (bus.B_VALID) w_next = ST_RESP;
      end
      ST_RESP: begin
        RSP_VALID = 1'b1;
        RSP_RDATA = r_rdata;
        RSP_ERR   = r_err;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (REQ_VALID) begin
          r_addr     <= REQ_ADDR;
          r_wdata    <= REQ_WDATA;
          r_size     <= REQ_SIZE;
          r_unsigned <= REQ_UNSIGNED;
          r_err      <= w_misaligned;
          r_rdata    <= '0;
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
        end
        ST_AWW: begin
          if (bus.AW_READY) r_aw_done <= 1'b1;
          if (bus.W_READY)  r_w_done  <= 1'b1;
        end
        ST_R: if (bus.R_VALID) begin
          r_err   <= resp_is_err(bus.R_RESP);
          r_rdata <= resp_is_err(bus.R_RESP) ? '0 : w_rdata_ext;
        end
        ST_B: if (bus.B_VALID) r_err <= resp_is_err(bus.B_RESP);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_dmem_master.sv
// Self-checking bench for axi4_lite_dmem_master: directed scenarios plus randomized
// transactions compared against an arithmetic reference model.
module tb_axi4_lite_dmem_master;
  import axi4_lite_dmem_master_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        REQ_VALID, REQ_WE, REQ_UNSIGNED;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        STALL, RSP_VALID, RSP_ERR;
  logic [31:0] RSP_RDATA;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_dmem_master_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  axi4_lite_dmem_master #(.DATA_W(32), .ADDR_W(32)) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .REQ_VALID    (REQ_VALID),
    .REQ_WE       (REQ_WE),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_WDATA    (REQ_WDATA),
    .REQ_SIZE     (REQ_SIZE),
    .REQ_UNSIGNED (REQ_UNSIGNED),
    .STALL        (STALL),
    .RSP_VALID    (RSP_VALID),
    .RSP_RDATA    (RSP_RDATA),
    .RSP_ERR      (RSP_ERR),
    .bus          (bus)
  );

  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [1:0] size; logic uns;
    int a_dly; int w_dly; int r_dly; logic [1:0] resp; logic [31:0] mem;
  } txn_t;

  typedef struct {
    int latency; int rsp_pulses; logic [31:0] rdata; logic err; int stall_cycles;
    int aw_cycles; int w_cycles; int ar_cycles; int changes;
    logic [31:0] aw_addr; logic [31:0] ar_addr; logic [31:0] w_data; logic [3:0] w_strb;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic logic m_mis(input txn_t t);
    return (t.size == 2'd3) || (t.size == SIZE_H && (t.addr % 2) != 0) || (t.size == SIZE_W && (t.addr % 4) != 0);
  endfunction

  function automatic logic m_err(input txn_t t);
    return m_mis(t) || (t.resp != RESP_OKAY);
  endfunction

  function automatic logic [31:0] m_rdata(input txn_t t);
    int unsigned off;
    longint v;
    off = t.addr % 4;
    if (t.we || m_err(t)) return 32'd0;
    v = longint'(t.mem / (32'd1 << (8 * off)));
    if (t.size == SIZE_B) begin
      v = v % 256;
      if (!t.uns && v >= 128) v = v - 256;
    end else if (t.size == SIZE_H) begin
      v = v % 65536;
      if (!t.uns && v >= 32768) v = v - 65536;
    end else v = longint'(t.mem);
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input txn_t t);
    longint v;
    v = longint'(t.wdata) * (longint'(1) << (8 * (t.addr % 4)));
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_strb(input txn_t t);
    int unsigned off;
    off = t.addr % 4;
    if (t.size == SIZE_B) return 4'(1 * (2 ** off));
    if (t.size == SIZE_H) return 4'(3 * (2 ** off));
    return 4'hF;
  endfunction

  function automatic int m_latency(input txn_t t);
    if (m_mis(t)) return 1;
    if (!t.we) return 3 + t.a_dly + t.r_dly;
    return 3 + ((t.a_dly > t.w_dly) ? t.a_dly : t.w_dly) + t.r_dly;
  endfunction

  // ---------------- CPU driver + responder (records observations only) ----------------
  task automatic drive_txn(input txn_t t, output obs_t o);
    int aw_seen, w_seen, ar_seen, rb_seen, last;
    aw_seen = 0; w_seen = 0; ar_seen = 0; rb_seen = 0; last = 300;
    o.latency = -1; o.rsp_pulses = 0; o.rdata = 'x; o.err = 1'bx; o.stall_cycles = 0;
    o.aw_cycles = 0; o.w_cycles = 0; o.ar_cycles = 0; o.changes = 0;
    o.aw_addr = 'x; o.ar_addr = 'x; o.w_data = 'x; o.w_strb = 'x;
    for (int cyc = 0; cyc <= last; cyc++) begin
      @(negedge ACLK);
      if (cyc == 0) begin
        REQ_VALID = 1'b1; REQ_WE = t.we; REQ_ADDR = t.addr; REQ_WDATA = t.wdata;
        REQ_SIZE = t.size; REQ_UNSIGNED = t.uns;
      end
      #1;
      if (STALL) o.stall_cycles++;
      if (RSP_VALID) begin
        o.rsp_pulses++;
        if (o.latency < 0) begin
          o.latency = cyc; o.rdata = RSP_RDATA; o.err = RSP_ERR; last = cyc + 1;
        end
        REQ_VALID = 1'b0;
      end
      if (bus.AW_VALID) begin
        if (o.aw_cycles == 0) o.aw_addr = bus.AW_ADDR; else if (bus.AW_ADDR !== o.aw_addr) o.changes++;
        o.aw_cycles++;
        bus.AW_READY = (aw_seen >= t.a_dly); aw_seen++;
      end else bus.AW_READY = ($urandom_range(0, 1) == 1);
      if (bus.W_VALID) begin
        if (o.w_cycles == 0) begin o.w_data = bus.W_DATA; o.w_strb = bus.W_STRB; end
        else if (bus.W_DATA !== o.w_data || bus.W_STRB !== o.w_strb) o.changes++;
        o.w_cycles++;
        bus.W_READY = (w_seen >= t.w_dly); w_seen++;
      end else bus.W_READY = ($urandom_range(0, 1) == 1);
      if (bus.AR_VALID) begin
        if (o.ar_cycles == 0) o.ar_addr = bus.AR_ADDR; else if (bus.AR_ADDR !== o.ar_addr) o.changes++;
        o.ar_cycles++;
        bus.AR_READY = (ar_seen >= t.a_dly); ar_seen++;
      end else bus.AR_READY = ($urandom_range(0, 1) == 1);
      if (bus.R_READY) begin bus.R_VALID = (rb_seen >= t.r_dly); rb_seen++; end
      else bus.R_VALID = 1'b0;
      bus.R_DATA = bus.R_VALID ? t.mem : $urandom;
      bus.R_RESP = bus.R_VALID ? t.resp : 2'b11;
      if (bus.B_READY) begin bus.B_VALID = (rb_seen >= t.r_dly); rb_seen++; end
      else bus.B_VALID = 1'b0;
      bus.B_RESP = bus.B_VALID ? t.resp : 2'b11;
    end
    REQ_VALID = 1'b0; bus.AW_READY = 1'b0; bus.W_READY = 1'b0; bus.AR_READY = 1'b0;
    bus.R_VALID = 1'b0; bus.B_VALID = 1'b0;
  endtask

  function automatic logic any_out();
    return |{STALL, RSP_VALID, RSP_RDATA, RSP_ERR, bus.AW_VALID, bus.AW_ADDR, bus.W_VALID,
             bus.W_DATA, bus.W_STRB, bus.B_READY, bus.AR_VALID, bus.AR_ADDR, bus.R_READY};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    ARESETn = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    REQ_SIZE = '0; REQ_UNSIGNED = 1'b0;
    bus.AW_READY = 1'b0; bus.W_READY = 1'b0; bus.B_VALID = 1'b0; bus.B_RESP = '0;
    bus.AR_READY = 1'b0; bus.R_VALID = 1'b0; bus.R_DATA = '0; bus.R_RESP = '0;
    @(negedge ACLK); @(negedge ACLK); #1;
    n_checks++; if (any_out() !== 1'b0) begin n_fail++; $display("FAIL reset_outputs got %b want 0", any_out()); end
    ARESETn = 1'b1;
    @(negedge ACLK); #1;
    n_checks++; if (any_out() !== 1'b0) begin n_fail++; $display("FAIL idle_outputs got %b want 0", any_out()); end
  endtask

  task automatic test_word_store();
    txn_t t; obs_t o;
    t = '{we:1'b1, addr:32'h10, wdata:32'hDEADBEEF, size:SIZE_W, uns:1'b0,
          a_dly:0, w_dly:0, r_dly:0, resp:RESP_OKAY, mem:32'h0};
    drive_txn(t, o);
    n_checks++; if (o.aw_addr !== 32'h10) begin n_fail++; $display("FAIL wstore aw_addr got %h want 10", o.aw_addr); end
    n_checks++; if (o.w_strb !== 4'b1111) begin n_fail++; $display("FAIL wstore strb got %b want 1111", o.w_strb); end
    n_checks++; if (o.w_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wstore wdata got %h want deadbeef", o.w_data); end
    n_checks++; if (o.latency !== 3) begin n_fail++; $display("FAIL wstore latency got %0d want 3", o.latency); end
    n_checks++; if (o.err !== 1'b0) begin n_fail++; $display("FAIL wstore err got %b want 0", o.err); end
    n_checks++; if (o.ar_cycles !== 0) begin n_fail++; $display("FAIL wstore ar_cycles got %0d want 0", o.ar_cycles); end
  endtask

  task automatic test_byte_store_aw_delay();
    txn_t t; obs_t o;
    t = '{we:1'b1, addr:32'h13, wdata:32'h000000A5, size:SIZE_B, uns:1'b0,
          a_dly:4, w_dly:0, r_dly:0, resp:RESP_OKAY, mem:32'h0};
    drive_txn(t, o);
    n_checks++; if (o.w_data !== 32'hA500_0000) begin n_fail++; $display("FAIL bstore wdata got %h want a5000000", o.w_data); end
    n_checks++; if (o.w_strb !== 4'b1000) begin n_fail++; $display("FAIL bstore strb got %b want 1000", o.w_strb); end
    n_checks++; if (o.w_cycles !== 1) begin n_fail++; $display("FAIL bstore w_cycles got %0d want 1", o.w_cycles); end
    n_checks++; if (o.aw_cycles !== 5) begin n_fail++; $display("FAIL bstore aw_cycles got %0d want 5", o.aw_cycles); end
    n_checks++; if (o.aw_addr !== 32'h10) begin n_fail++; $display("FAIL bstore aw_addr got %h want 10", o.aw_addr); end
    n_checks++; if (o.changes !== 0) begin n_fail++; $display("FAIL bstore stability got %0d changes want 0", o.changes); end
    n_checks++; if (o.rsp_pulses !== 1) begin n_fail++; $display("FAIL bstore pulses got %0d want 1", o.rsp_pulses); end
    n_checks++; if (o.latency !== 7) begin n_fail++; $display("FAIL bstore latency got %0d want 7", o.latency); end
  endtask

  task automatic test_loads();
    logic [31:0] addrs [5];
    logic [1:0]  sizes [5];
    logic        unss  [5];
    logic [31:0] exps  [5];
    txn_t t; obs_t o;
    addrs = '{32'h2, 32'h0, 32'h0, 32'h2, 32'h2};
    sizes = '{SIZE_B, SIZE_B, SIZE_B, SIZE_H, SIZE_H};
    unss  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exps  = '{32'h0000_0070, 32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_8070, 32'h0000_8070};
    for (int i = 0; i < 5; i++) begin
      t = '{we:1'b0, addr:addrs[i], wdata:32'h0, size:sizes[i], uns:unss[i],
            a_dly:0, w_dly:0, r_dly:0, resp:RESP_OKAY, mem:32'h8070_F0FF};
      drive_txn(t, o);
      n_checks++; if (o.rdata !== exps[i]) begin n_fail++; $display("FAIL load[%0d] rdata got %h want %h", i, o.rdata, exps[i]); end
      n_checks++; if (o.latency !== 3) begin n_fail++; $display("FAIL load[%0d] latency got %0d want 3", i, o.latency); end
      n_checks++; if (o.ar_addr !== 32'h0) begin n_fail++; $display("FAIL load[%0d] ar_addr got %h want 0", i, o.ar_addr); end
      n_checks++; if (o.aw_cycles !== 0) begin n_fail++; $display("FAIL load[%0d] aw_cycles got %0d want 0", i, o.aw_cycles); end
    end
  endtask

  task automatic test_misaligned();
    txn_t t; obs_t o;
    t = '{we:1'b0, addr:32'h6, wdata:32'h0, size:SIZE_W, uns:1'b0,
          a_dly:0, w_dly:0, r_dly:0, resp:RESP_OKAY, mem:32'h1234_5678};
    drive_txn(t, o);
    n_checks++; if (o.ar_cycles !== 0) begin n_fail++; $display("FAIL mis ar_cycles got %0d want 0", o.ar_cycles); end
    n_checks++; if (o.latency !== 1) begin n_fail++; $display("FAIL mis latency got %0d want 1", o.latency); end
    n_checks++; if (o.err !== 1'b1) begin n_fail++; $display("FAIL mis err got %b want 1", o.err); end
    n_checks++; if (o.rdata !== 32'h0) begin n_fail++; $display("FAIL mis rdata got %h want 0", o.rdata); end
  endtask

  task automatic test_read_error();
    txn_t t; obs_t o;
    t = '{we:1'b0, addr:32'h4, wdata:32'h0, size:SIZE_W, uns:1'b0,
          a_dly:0, w_dly:0, r_dly:3, resp:RESP_SLVERR, mem:32'hCAFE_F00D};
    drive_txn(t, o);
    n_checks++; if (o.err !== 1'b1) begin n_fail++; $display("FAIL rderr err got %b want 1", o.err); end
    n_checks++; if (o.latency !== 6) begin n_fail++; $display("FAIL rderr latency got %0d want 6", o.latency); end
    n_checks++; if (o.stall_cycles !== 6) begin n_fail++; $display("FAIL rderr stall_cycles got %0d want 6", o.stall_cycles); end
    n_checks++; if (o.rdata !== 32'h0) begin n_fail++; $display("FAIL rderr rdata got %h want 0", o.rdata); end
  endtask

  task automatic test_reset_mid_b();
    txn_t t; obs_t o;
    bit found;
    found = 1'b0;
    @(negedge ACLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h20; REQ_WDATA = 32'h1111_2222;
    REQ_SIZE = SIZE_W; REQ_UNSIGNED = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      bus.AW_READY = bus.AW_VALID; bus.W_READY = bus.W_VALID; bus.B_VALID = 1'b0;
      if (bus.B_READY) begin found = 1'b1; break; end
      @(negedge ACLK);
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rstb reach_b got %b want 1", found); end
    ARESETn = 1'b0; REQ_VALID = 1'b0; bus.AW_READY = 1'b0; bus.W_READY = 1'b0;
    @(negedge ACLK); #1;
    n_checks++; if (any_out() !== 1'b0) begin n_fail++; $display("FAIL rstb outputs got %b want 0", any_out()); end
    ARESETn = 1'b1;
    t = '{we:1'b0, addr:32'h21, wdata:32'h0, size:SIZE_B, uns:1'b1,
          a_dly:1, w_dly:0, r_dly:0, resp:RESP_OKAY, mem:32'h0000_9A00};
    drive_txn(t, o);
    n_checks++; if (o.rdata !== 32'h9A) begin n_fail++; $display("FAIL rstb rdata got %h want 9a", o.rdata); end
    n_checks++; if (o.latency !== 4) begin n_fail++; $display("FAIL rstb latency got %0d want 4", o.latency); end
  endtask

  task automatic test_random();
    txn_t t; obs_t o;
    logic [1:0] resps [4];
    resps = '{RESP_OKAY, RESP_OKAY, RESP_SLVERR, 2'b01};
    for (int i = 0; i < 60; i++) begin
      t.we = $urandom_range(0, 1) == 1; t.addr = $urandom; t.wdata = $urandom;
      t.size = 2'($urandom_range(0, 3)); t.uns = $urandom_range(0, 1) == 1;
      t.a_dly = $urandom_range(0, 3); t.w_dly = $urandom_range(0, 3); t.r_dly = $urandom_range(0, 3);
      t.resp = resps[$urandom_range(0, 3)]; t.mem = $urandom;
      if (!t.we) t.w_dly = 0;
      drive_txn(t, o);
      n_checks++; if (o.latency !== m_latency(t)) begin n_fail++; $display("FAIL rnd[%0d] latency got %0d want %0d", i, o.latency, m_latency(t)); end
      n_checks++; if (o.rdata !== m_rdata(t)) begin n_fail++; $display("FAIL rnd[%0d] rdata got %h want %h", i, o.rdata, m_rdata(t)); end
      n_checks++; if (o.err !== m_err(t)) begin n_fail++; $display("FAIL rnd[%0d] err got %b want %b", i, o.err, m_err(t)); end
      n_checks++; if (o.rsp_pulses !== 1) begin n_fail++; $display("FAIL rnd[%0d] pulses got %0d want 1", i, o.rsp_pulses); end
      n_checks++; if (o.stall_cycles !== m_latency(t)) begin n_fail++; $display("FAIL rnd[%0d] stall_cycles got %0d want %0d", i, o.stall_cycles, m_latency(t)); end
      n_checks++; if (o.changes !== 0) begin n_fail++; $display("FAIL rnd[%0d] stability got %0d changes want 0", i, o.changes); end
      if (m_mis(t)) begin
        n_checks++; if (o.aw_cycles + o.w_cycles + o.ar_cycles !== 0) begin n_fail++; $display("FAIL rnd[%0d] mis_bus got %0d want 0", i, o.aw_cycles + o.w_cycles + o.ar_cycles); end
      end else if (t.we) begin
        n_checks++; if (o.aw_cycles !== t.a_dly + 1) begin n_fail++; $display("FAIL rnd[%0d] aw_cycles got %0d want %0d", i, o.aw_cycles, t.a_dly + 1); end
        n_checks++; if (o.w_cycles !== t.w_dly + 1) begin n_fail++; $display("FAIL rnd[%0d] w_cycles got %0d want %0d", i, o.w_cycles, t.w_dly + 1); end
        n_checks++; if (o.aw_addr !== (t.addr & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL rnd[%0d] aw_addr got %h want %h", i, o.aw_addr, t.addr & 32'hFFFF_FFFC); end
        n_checks++; if (o.w_data !== m_wdata(t)) begin n_fail++; $display("FAIL rnd[%0d] wdata got %h want %h", i, o.w_data, m_wdata(t)); end
        n_checks++; if (o.w_strb !== m_strb(t)) begin n_fail++; $display("FAIL rnd[%0d] strb got %b want %b", i, o.w_strb, m_strb(t)); end
        n_checks++; if (o.ar_cycles !== 0) begin n_fail++; $display("FAIL rnd[%0d] ar_cycles got %0d want 0", i, o.ar_cycles); end
      end else begin
        n_checks++; if (o.ar_cycles !== t.a_dly + 1) begin n_fail++; $display("FAIL rnd[%0d] ar_cycles got %0d want %0d", i, o.ar_cycles, t.a_dly + 1); end
        n_checks++; if (o.ar_addr !== (t.addr & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL rnd[%0d] ar_addr got %h want %h", i, o.ar_addr, t.addr & 32'hFFFF_FFFC); end
        n_checks++; if (o.aw_cycles + o.w_cycles !== 0) begin n_fail++; $display("FAIL rnd[%0d] aw_w_cycles got %0d want 0", i, o.aw_cycles + o.w_cycles); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_store_aw_delay();
    test_loads();
    test_misaligned();
    test_read_error();
    test_reset_mid_b();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
